// File: rtl/twos_deser.sv
// Serial-to-parallel deserializer with an optional serial +1, turning an LSB-first
// 1's-complement bit stream into 2's-complement words behind a one-deep holding register.
module twos_deser #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned ADD_ONE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_data,
  input  logic             in_valid,
  input  logic             sof,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overflow,
  output logic             busy
);

  localparam int unsigned     CntW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastIdx   = CntW'(WIDTH - 1);
  localparam logic            CarryInit = (ADD_ONE != 0);

  typedef enum logic {StIdle, StCollect} state_e;

  state_e           r_state, w_state_nxt;
  logic [CntW-1:0]  r_count, w_count_nxt;
  logic             r_carry, w_carry_nxt;
  logic [WIDTH-1:0] r_shift, w_shift_nxt;
  logic [WIDTH-1:0] r_out_data, w_out_data_nxt;
  logic             r_out_carry, w_out_carry_nxt;
  logic             r_out_valid, w_out_valid_nxt;
  logic             r_overflow, w_overflow_nxt;

  logic [CntW-1:0]  w_idx;
  logic [WIDTH-1:0] w_word;
  logic             w_accept, w_done, w_carry_in, w_sum, w_carry_out;

  // A sof restarts the frame whatever the state, so bit index and carry restart too.
  always_comb begin
    w_accept    = in_valid && (sof || (r_state == StCollect));
    w_idx       = sof ? '0 : r_count;
    w_carry_in  = sof ? CarryInit : r_carry;
    w_sum       = in_data ^ w_carry_in;
    w_carry_out = in_data & w_carry_in;
    w_word      = (sof ? '0 : r_shift) | (WIDTH'(w_sum) << w_idx);
    w_done      = w_accept && (w_idx == LastIdx);
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_count_nxt     = r_count;
    w_carry_nxt     = r_carry;
    w_shift_nxt     = r_shift;
    w_out_data_nxt  = r_out_data;
    w_out_carry_nxt = r_out_carry;
    w_out_valid_nxt = r_out_valid;
    w_overflow_nxt  = r_overflow;

    if (w_accept) begin
      if (w_done) begin
        // Shift register is cleared so the next frame can OR bits into zeros.
        w_state_nxt = StIdle;
        w_count_nxt = '0;
        w_carry_nxt = CarryInit;
        w_shift_nxt = '0;
      end else begin
        w_state_nxt = StCollect;
        w_count_nxt = w_idx + 1'b1;
        w_carry_nxt = w_carry_out;
        w_shift_nxt = w_word;
      end
    end

    if (w_done) begin
      if (!r_out_valid || out_ready) begin
        w_out_data_nxt  = w_word;
        w_out_carry_nxt = w_carry_out;
        w_out_valid_nxt = 1'b1;
      end else begin
        w_overflow_nxt = 1'b1;
      end
    end else if (r_out_valid && out_ready) begin
      w_out_valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= StIdle;
      r_count     <= '0;
      r_carry     <= CarryInit;
      r_shift     <= '0;
      r_out_data  <= '0;
      r_out_carry <= 1'b0;
      r_out_valid <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_count     <= w_count_nxt;
      r_carry     <= w_carry_nxt;
      r_shift     <= w_shift_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_carry <= w_out_carry_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_overflow  <= w_overflow_nxt;
    end
  end

  assign out_data  = r_out_data;
  assign out_carry = r_out_carry;
  assign out_valid = r_out_valid;
  assign overflow  = r_overflow;
  assign busy      = (r_state == StCollect);

endmodule

// File: tb/tb_twos_deser.sv
// Scoreboard bench for twos_deser: one instance with the serial +1, one without,
// both fed the same directed bit streams.
module tb_twos_deser;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_data = 1'b0;
  logic       in_valid = 1'b0;
  logic       sof = 1'b0;
  logic       out_ready = 1'b0;

  logic [7:0] o1_data, o0_data;
  logic       o1_carry, o0_carry, o1_valid, o0_valid;
  logic       o1_ovf, o0_ovf, o1_busy, o0_busy;

  int checks = 0;
  int errors = 0;

  logic [8:0] q1[$];
  logic [8:0] q0[$];

  always #5 clk = ~clk;

  twos_deser #(.WIDTH(8), .ADD_ONE(1)) u_add1 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .sof(sof),
    .out_data(o1_data), .out_carry(o1_carry), .out_valid(o1_valid),
    .out_ready(out_ready), .overflow(o1_ovf), .busy(o1_busy)
  );

  twos_deser #(.WIDTH(8), .ADD_ONE(0)) u_add0 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .sof(sof),
    .out_data(o0_data), .out_carry(o0_carry), .out_valid(o0_valid),
    .out_ready(out_ready), .overflow(o0_ovf), .busy(o0_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives n bits of w LSB first, one per clock; sof on the first bit if requested.
  task automatic send_bits(input logic [7:0] w, input int n, input bit with_sof);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = w[i];
      sof      = with_sof && (i == 0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    sof      = 1'b0;
    in_data  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: a word is consumed on the edge after out_valid && out_ready is seen here.
  always @(negedge clk) begin
    logic [8:0] e;
    if (o1_valid && out_ready) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_add1_unexpected: got data 0x%0h, expected no word", o1_data);
      end else begin
        e = q1.pop_front();
        chk("sb_add1_data", 32'(o1_data), 32'(e[7:0]));
        chk("sb_add1_carry", 32'(o1_carry), 32'(e[8]));
      end
    end
    if (o0_valid && out_ready) begin
      if (q0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_add0_unexpected: got data 0x%0h, expected no word", o0_data);
      end else begin
        e = q0.pop_front();
        chk("sb_add0_data", 32'(o0_data), 32'(e[7:0]));
        chk("sb_add0_carry", 32'(o0_carry), 32'(e[8]));
      end
    end
  end

  initial begin
    // Reset state
    #2;
    chk("rst_valid1", 32'(o1_valid), 0);
    chk("rst_data1", 32'(o1_data), 0);
    chk("rst_carry1", 32'(o1_carry), 0);
    chk("rst_ovf1", 32'(o1_ovf), 0);
    chk("rst_busy1", 32'(o1_busy), 0);
    chk("rst_valid0", 32'(o0_valid), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle(1);

    // 1's complement of 5 (0xFA): +1 gives 0xFB, plain gives 0xFA
    out_ready = 1'b1;
    q1.push_back({1'b0, 8'hFB});
    q0.push_back({1'b0, 8'hFA});
    send_bits(8'hFA, 1, 1'b1);
    chk("busy_after_bit0", 32'(o1_busy), 1);
    send_bits(8'h7D, 7, 1'b0);  // remaining bits 1..7 of 0xFA
    chk("latency_valid1", 32'(o1_valid), 1);
    chk("latency_valid0", 32'(o0_valid), 1);
    chk("busy_after_last", 32'(o1_busy), 0);
    idle(1);
    chk("valid_drop_after_ready", 32'(o1_valid), 0);

    // Negative zero: 0xFF + 1 = 0x00 carry 1
    q1.push_back({1'b1, 8'h00});
    q0.push_back({1'b0, 8'hFF});
    send_bits(8'hFF, 8, 1'b1);
    chk("negzero_carry1", 32'(o1_carry), 1);
    idle(1);

    // Back-to-back frames, no dead cycle
    q1.push_back({1'b0, 8'h3D});
    q0.push_back({1'b0, 8'h3C});
    q1.push_back({1'b0, 8'h81});
    q0.push_back({1'b0, 8'h80});
    send_bits(8'h3C, 8, 1'b1);
    send_bits(8'h80, 8, 1'b1);
    chk("b2b_second_valid", 32'(o1_valid), 1);
    idle(2);

    // Stalled consumer: second frame dropped, holding register stable, overflow sticky
    out_ready = 1'b0;
    q1.push_back({1'b0, 8'hFB});
    q0.push_back({1'b0, 8'hFA});
    send_bits(8'hFA, 8, 1'b1);
    send_bits(8'h0F, 8, 1'b1);
    idle(1);
    chk("stall_data1", 32'(o1_data), 32'h FB);
    chk("stall_data0", 32'(o0_data), 32'h FA);
    chk("stall_ovf1", 32'(o1_ovf), 1);
    chk("stall_ovf0", 32'(o0_ovf), 1);
    chk("stall_valid1", 32'(o1_valid), 1);
    out_ready = 1'b1;
    idle(1);
    chk("stall_release_valid", 32'(o1_valid), 0);
    chk("ovf_sticky", 32'(o1_ovf), 1);

    // Asynchronous reset mid-frame with a pending word
    out_ready = 1'b0;
    send_bits(8'h12, 8, 1'b1);  // pending word, discarded by reset
    send_bits(8'h55, 4, 1'b1);
    chk("midframe_busy", 32'(o1_busy), 1);
    #2;
    rst = 1'b0;
    #1;
    chk("async_valid", 32'(o1_valid), 0);
    chk("async_data", 32'(o1_data), 0);
    chk("async_carry", 32'(o1_carry), 0);
    chk("async_ovf", 32'(o1_ovf), 0);
    chk("async_busy", 32'(o1_busy), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    send_bits(8'hFF, 8, 1'b0);
    chk("nosof_valid", 32'(o1_valid), 0);
    chk("nosof_busy", 32'(o1_busy), 0);

    // sof reasserted at bit 4 discards the partial word
    out_ready = 1'b1;
    q1.push_back({1'b0, 8'h01});
    q0.push_back({1'b0, 8'h00});
    send_bits(8'hFF, 4, 1'b1);
    send_bits(8'h00, 8, 1'b1);
    chk("resof_valid", 32'(o1_valid), 1);
    idle(2);
    chk("resof_ovf1", 32'(o1_ovf), 0);
    chk("resof_ovf0", 32'(o0_ovf), 0);
    chk("resof_valid_drop", 32'(o1_valid), 0);

    chk("sb_add1_drained", 32'(q1.size()), 0);
    chk("sb_add0_drained", 32'(q0.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
